// File: rtl/ftq_queue.sv
// Fetch Target Queue: buffers BPU fetch blocks, issues them in order to the IFU
// and holds each one until the backend commits it.
module ftq_queue #(
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int PTRW       = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rest_i,
    input  logic                  bpu_valid_i,
    input  logic [ADDR_WIDTH-1:0] bpu_pc_i,
    input  logic [ADDR_WIDTH-1:0] bpu_target_i,
    input  logic                  bpu_taken_i,
    output logic                  ifu_valid_o,
    input  logic                  ifu_ready_i,
    output logic [ADDR_WIDTH-1:0] ifu_pc_o,
    output logic [ADDR_WIDTH-1:0] ifu_target_o,
    output logic                  ifu_taken_o,
    output logic [PTRW-1:0]       ifu_ptr_o,
    input  logic                  commit_valid_i,
    input  logic                  ftq_stop_i,
    input  logic                  ftq_flash_i,
    output logic                  ftq_req_o,
    output logic [PTRW:0]         count_o,
    output logic                  ovf_err_o
);

    localparam logic [PTRW:0] DEPTH_P = (PTRW+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] pc_mem_q  [DEPTH];
    logic [ADDR_WIDTH-1:0] tgt_mem_q [DEPTH];
    logic                  tkn_mem_q [DEPTH];

    logic [PTRW:0] enq_q, enq_d;
    logic [PTRW:0] fetch_q, fetch_d;
    logic [PTRW:0] commit_q, commit_d;
    logic          ftq_req_q, ftq_req_d;
    logic          ovf_err_q, ovf_err_d;

    logic [PTRW:0] count;
    logic [PTRW:0] count_d;
    logic          full;
    logic          empty;
    logic          ifu_valid;
    logic          accept;
    logic          enq_fire;
    logic          drop;
    logic          issue_fire;
    logic          commit_ok;
    logic          commit_bad;

    always_comb begin
        count      = enq_q - commit_q;
        full       = (count == DEPTH_P);
        empty      = (fetch_q == enq_q);
        ifu_valid  = ~empty & ~ftq_flash_i;
        accept     = bpu_valid_i & ~ftq_stop_i & ~ftq_flash_i;
        enq_fire   = accept & ~full;
        drop       = accept & full;
        issue_fire = ifu_valid & ifu_ready_i;
        commit_ok  = commit_valid_i & (commit_q != fetch_q);
        commit_bad = commit_valid_i & (commit_q == fetch_q);

        commit_d = commit_q + {{PTRW{1'b0}}, commit_ok};
        enq_d    = enq_q + {{PTRW{1'b0}}, enq_fire};
        fetch_d  = fetch_q + {{PTRW{1'b0}}, issue_fire};
        // A flash keeps only committed work: the commit lands first, then
        // everything younger is discarded.
        if (ftq_flash_i) begin
            enq_d   = commit_d;
            fetch_d = commit_d;
        end

        count_d   = enq_d - commit_d;
        ftq_req_d = (count_d == DEPTH_P);
        ovf_err_d = ovf_err_q | drop | commit_bad;
    end

    always_ff @(posedge clk_i) begin
        if (!rest_i) begin
            enq_q     <= '0;
            fetch_q   <= '0;
            commit_q  <= '0;
            ftq_req_q <= 1'b0;
            ovf_err_q <= 1'b0;
        end else begin
            enq_q     <= enq_d;
            fetch_q   <= fetch_d;
            commit_q  <= commit_d;
            ftq_req_q <= ftq_req_d;
            ovf_err_q <= ovf_err_d;
        end
    end

    // Entry storage needs no reset; pointers define what is live.
    always_ff @(posedge clk_i) begin
        if (rest_i && enq_fire) begin
            pc_mem_q[enq_q[PTRW-1:0]]  <= bpu_pc_i;
            tgt_mem_q[enq_q[PTRW-1:0]] <= bpu_target_i;
            tkn_mem_q[enq_q[PTRW-1:0]] <= bpu_taken_i;
        end
    end

    assign ifu_valid_o  = ifu_valid;
    assign ifu_pc_o     = pc_mem_q[fetch_q[PTRW-1:0]];
    assign ifu_target_o = tgt_mem_q[fetch_q[PTRW-1:0]];
    assign ifu_taken_o  = tkn_mem_q[fetch_q[PTRW-1:0]];
    assign ifu_ptr_o    = fetch_q[PTRW-1:0];
    assign ftq_req_o    = ftq_req_q;
    assign count_o      = count;
    assign ovf_err_o    = ovf_err_q;

endmodule

// File: doc/ftq_queue.md
Name: ftq_queue

Overview:
- Fetch Target Queue between the BPU and the ICache fetch stage.
- Buffers predicted fetch blocks (PC, predicted target, taken bit) from the BPU and issues them in order to the IFU.
- Holds each entry until the backend commits it.
- Is the source of the FTQ-full stall request to the front-end control block and the consumer of its FTQ stop/flash outputs.

Parameters:
DEPTH, 8, number of entries; power of two, >= 4.
ADDR_WIDTH, 32, PC/target width.
PTRW, log2(DEPTH), entry index width; pointers carry one extra wrap bit (PTRW+1).

Ports:
Clk  in  1  clock; all state updates on rising edge.
Rest  in  1  reset; synchronous, active-low.
BpuValid  in  1  BPU presents a prediction this cycle.
BpuPc  in  ADDR_WIDTH  fetch block start PC.
BpuTarget  in  ADDR_WIDTH  predicted next PC.
BpuTaken  in  1  predicted taken.
IfuValid  out  1  entry at fetch pointer available.
IfuReady  in  1  ICache accepts the entry.
IfuPc  out  ADDR_WIDTH  PC of entry at fetch pointer.
IfuTarget  out  ADDR_WIDTH  target of entry at fetch pointer.
IfuTaken  out  1  taken bit of entry at fetch pointer.
IfuPtr  out  PTRW  index of issued entry, used by the backend for commit tracking.
CommitValid  in  1  backend retires the oldest entry.
FTQStop  in  1  stop from front-end control.
FTQFlash  in  1  flash from front-end control (ROB redirect).
FTQReq  out  1  queue full, request front-end stall.
Count  out  PTRW+1  occupancy (enq - commit).
OvfErr  out  1  sticky protocol-error flag.

Behaviour:
- State:
  - Entry array of DEPTH x {Pc, Target, Taken}.
  - Three pointers of PTRW+1 bits each: enq, fetch, commit. Invariant: commit <= fetch <= enq (modulo wrap).
- Reset (Rest=0 at an edge, including mid-operation):
  - enq = fetch = commit = 0.
  - FTQReq = 0, OvfErr = 0, IfuValid = 0, Count = 0.
  - Entry contents don't-care.
- Derived values:
  - Count = enq - commit (PTRW+1 bits, modular).
  - full = Count == DEPTH.
  - empty-for-fetch = fetch == enq.
- Enqueue:
  - Occurs when BpuValid & ~FTQStop & ~FTQFlash & ~full.
  - Writes entry[enq[PTRW-1:0]] and increments enq.
  - BpuValid & ~FTQStop & ~FTQFlash & full: entry dropped, OvfErr set (sticky until reset).
- Issue:
  - IfuValid = ~empty-for-fetch & ~FTQFlash, driven combinationally from registers.
  - IfuPc/IfuTarget/IfuTaken/IfuPtr read entry[fetch] combinationally.
  - IfuValid & IfuReady advances fetch.
  - No enqueue-to-issue bypass: a new entry is visible to the IFU one cycle after it is written.
  - FTQStop does NOT gate issue. This avoids deadlock, since FTQReq feeds FTQStop.
- Commit:
  - CommitValid & (commit != fetch) increments commit.
  - CommitValid with commit == fetch is ignored and sets OvfErr.
- Flash (FTQFlash=1):
  - Commit is applied first: commit_n = commit + valid commit.
  - Then enq <= commit_n, fetch <= commit_n.
  - All uncommitted entries are discarded.
  - Same-cycle enqueue and issue handshake are suppressed.
- FTQReq:
  - Registered; FTQReq <= (next Count == DEPTH).
  - Never asserted during the reset cycle.
  - Deasserts the cycle after a commit or flash drops Count below DEPTH.
- Wrap-around: index = ptr[PTRW-1:0]. The wrap bit distinguishes full from empty.
- Simultaneous enqueue + commit at full is impossible: enqueue is blocked by full. At non-full, both apply and Count is unchanged.

Test Plan:
- Reset: hold Rest=0 2 cycles with BpuValid=1 -> Count=0, IfuValid=0, FTQReq=0, OvfErr=0.
- In-order issue: enqueue PCs 0x1C000000, 0x1C000010, 0x1C000020 back-to-back with IfuReady=1 -> IfuValid rises the cycle after the first enqueue; IfuPc sequence 0x1C000000/10/20 with IfuPtr 0/1/2; then IfuValid=0.
- Full: IfuReady=0, 8 consecutive enqueues -> Count=8; FTQReq=1 in the cycle after the 8th write. A 9th BpuValid with FTQStop=0 is dropped and OvfErr=1.
- Drain from full: issue 1, then CommitValid 1 cycle -> Count=7 and FTQReq=0 on the next cycle; enqueue accepted again.
- Flash: 5 enqueued, 2 issued, 0 committed; assert FTQFlash with CommitValid=1 and BpuValid=1 -> next cycle enq=fetch=commit=1, Count=0, IfuValid=0, BPU entry not written.
- Wrap: 20 enqueue/issue/commit triples in a streaming pattern -> IfuPc order matches enqueue order across pointer wrap; Count stays <= 8; OvfErr=0.
